// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store initiator between the RISC-V core and word-wide data memory
// Checks alignment, issues one byte-enabled word request and returns the extended load lane.
module lsu_ctrl #(
  parameter int AW      = 9,
  parameter int TIMEOUT = 15
) (
  input  logic          clkd,
  input  logic          rst_n,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic          lsu_store,
  input  logic [2:0]    L_inst,
  input  logic [1:0]    S_inst,
  input  logic [31:0]   lsu_addr,
  input  logic [31:0]   lsu_wdata,
  output logic          lsu_done,
  output logic [31:0]   lsu_rdata,
  output logic          lsu_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_DONE} state_t;
  state_t state_q, state_d;

  logic          store_q;
  logic          uns_q;
  logic [1:0]    size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] cnt_q;

  logic          src_store;
  logic          src_uns;
  logic [1:0]    src_size;
  logic [AW+1:0] src_addr;
  logic [31:0]   src_wdata;
  logic          illegal;
  logic          misaligned;
  logic          timeout;
  logic [15:0]   lane;
  logic [31:0]   ext;

  logic          ready_d;
  logic          done_d;
  logic          req_d;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [31:0]   rdata_d;
  logic          err_d;

  logic          unused_addr_bits;
  assign unused_addr_bits = ^lsu_addr[31:AW+2];

  // Size code shared by loads and stores: 00 word, 01 byte, 10 half, 11 illegal.
  always_comb begin
    if (state_q == ST_IDLE) begin
      src_store = lsu_store;
      src_size  = lsu_store ? S_inst : L_inst[1:0];
      src_uns   = ~lsu_store & L_inst[2];
      src_addr  = lsu_addr[AW+1:0];
      src_wdata = lsu_wdata;
    end else begin
      src_store = store_q;
      src_size  = size_q;
      src_uns   = uns_q;
      src_addr  = addr_q;
      src_wdata = wdata_q;
    end
  end

  assign illegal    = (src_size == 2'b11) || (!src_store && src_uns && src_size == 2'b00);
  assign misaligned = (src_size == 2'b00 && src_addr[1:0] != 2'b00) ||
                      (src_size == 2'b10 && src_addr[0]);
  assign timeout    = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clkd or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (lsu_valid) begin
          state_d = (illegal || misaligned) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_gnt) begin
          state_d = store_q ? ST_DONE : ST_WAIT;
        end else if (timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid || timeout) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clkd or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == ST_IDLE && lsu_valid) begin
      store_q <= src_store;
      uns_q   <= src_uns;
      size_q  <= src_size;
      addr_q  <= src_addr;
      wdata_q <= src_wdata;
    end
  end

  // Counts every cycle spent in REQ and WAIT combined.
  always_ff @(posedge clkd or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      cnt_q <= '0;
    end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign lane = 16'(mem_rdata >> {addr_q[1:0], 3'b000});

  always_comb begin
    case (size_q)
      2'b01:   ext = uns_q ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
      2'b10:   ext = uns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: ext = mem_rdata;
    endcase
  end

  // Output values are computed for the state being entered and then registered.
  always_comb begin
    ready_d = (state_d == ST_IDLE);
    done_d  = (state_d == ST_DONE);
    req_d   = (state_d == ST_REQ);
    we_d    = req_d & src_store;
    addr_d  = req_d ? src_addr[AW+1:2] : '0;
    be_d    = 4'b0000;
    wdata_d = 32'b0;
    if (req_d) begin
      case (src_size)
        2'b01: begin
          be_d    = 4'b0001 << src_addr[1:0];
          wdata_d = {4{src_wdata[7:0]}};
        end
        2'b10: begin
          be_d    = 4'b0011 << src_addr[1:0];
          wdata_d = {2{src_wdata[15:0]}};
        end
        default: begin
          be_d    = 4'b1111;
          wdata_d = src_wdata;
        end
      endcase
    end
    rdata_d = lsu_rdata;
    err_d   = lsu_err;
    if (state_d == ST_DONE) begin
      if (state_q == ST_WAIT && mem_rvalid) begin
        rdata_d = ext;
        err_d   = 1'b0;
      end else if (state_q == ST_REQ && mem_gnt) begin
        rdata_d = 32'b0;
        err_d   = 1'b0;
      end else begin
        rdata_d = 32'b0;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clkd or negedge rst_n) begin
    if (!rst_n) begin
      lsu_ready <= 1'b0;
      lsu_done  <= 1'b0;
      lsu_rdata <= 32'b0;
      lsu_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'b0;
    end else begin
      lsu_ready <= ready_d;
      lsu_done  <= done_d;
      lsu_rdata <= rdata_d;
      lsu_err   <= err_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_be    <= be_d;
      mem_wdata <= wdata_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl with a behavioural memory model
module tb_lsu_ctrl;
  localparam int AW  = 9;
  localparam int TMO = 15;

  logic          clkd;
  logic          rst_n;
  logic          lsu_valid;
  logic          lsu_ready;
  logic          lsu_store;
  logic [2:0]    L_inst;
  logic [1:0]    S_inst;
  logic [31:0]   lsu_addr;
  logic [31:0]   lsu_wdata;
  logic          lsu_done;
  logic [31:0]   lsu_rdata;
  logic          lsu_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.AW(AW), .TIMEOUT(TMO)) dut (
    .clkd(clkd), .rst_n(rst_n), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
    .lsu_store(lsu_store), .L_inst(L_inst), .S_inst(S_inst), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial begin
    clkd = 1'b0;
    forever #5 clkd = ~clkd;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes, 0 for an illegal type.
  function automatic int size_of(input bit st, input logic [2:0] li, input logic [1:0] si);
    if (st) return (si == 2'd0) ? 4 : (si == 2'd1) ? 1 : (si == 2'd2) ? 2 : 0;
    case (li)
      3'd0:       return 4;
      3'd1, 3'd5: return 1;
      3'd2, 3'd6: return 2;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] li, input logic [31:0] a,
                                           input logic [31:0] word);
    longint w, v, n;
    int sh;
    if (li == 3'd0) return word;
    n  = (li == 3'd1 || li == 3'd5) ? 8 : 16;
    sh = 8 * int'(a % 4);
    w  = {32'b0, word};
    v  = (w >> sh) % (longint'(1) << n);
    if ((li == 3'd1 || li == 3'd2) && v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clkd);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"}, {31'b0, mem_req}, 32'd0);
    chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
    chk({tag, "_addr"}, {23'b0, mem_addr}, 32'd0);
    chk({tag, "_be"}, {28'b0, mem_be}, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_done"}, {31'b0, lsu_done}, 32'd0);
    chk({tag, "_rdata"}, lsu_rdata, 32'd0);
    chk({tag, "_err"}, {31'b0, lsu_err}, 32'd0);
  endtask

  // One transaction: gdly = REQ cycles before gnt, rdly = cycles from gnt to rvalid.
  task automatic run(input string tag, input bit st, input logic [2:0] li, input logic [1:0] si,
                     input logic [31:0] a, input logic [31:0] wd, input int gdly, input int rdly,
                     input logic [31:0] word);
    int sz, done_cyc, req_end, gcyc, rcyc;
    bit bad, okg, ok;
    logic [31:0] e_rd, e_be, e_wd;
    logic e_err;
    sz   = size_of(st, li, si);
    bad  = (sz == 0) ? 1'b1 : (a % 32'(sz) != 0);
    e_be = (sz == 4) ? 32'd15 : ((32'd1 << sz) - 1) << int'(a % 4);
    e_wd = (sz == 1) ? (wd % 256) * 32'h0101_0101 : (sz == 2) ? (wd % 65536) * 32'h0001_0001 : wd;
    okg  = !bad && gdly <= TMO - 1;
    ok   = okg && (st || gdly + rdly <= TMO - 1);
    if (bad) begin
      done_cyc = 1; req_end = 0;
    end else begin
      done_cyc = ok ? (st ? gdly + 2 : gdly + rdly + 2) : TMO + 1;
      req_end  = okg ? gdly + 1 : TMO;
    end
    gcyc  = okg ? gdly + 1 : -1;
    rcyc  = (ok && !st) ? gdly + 1 + rdly : -1;
    e_err = !ok;
    e_rd  = (ok && !st) ? load_val(li, a, word) : 32'd0;

    chk({tag, "_ready"}, {31'b0, lsu_ready}, 32'd1);
    lsu_valid = 1'b1; lsu_store = st; L_inst = li; S_inst = si; lsu_addr = a; lsu_wdata = wd;
    for (int c = 1; c <= done_cyc; c++) begin
      tick();
      chk({tag, "_req"}, {31'b0, mem_req}, {31'b0, c <= req_end});
      chk({tag, "_done"}, {31'b0, lsu_done}, {31'b0, c == done_cyc});
      if (c <= req_end) begin
        chk({tag, "_we"}, {31'b0, mem_we}, {31'b0, st});
        chk({tag, "_addr"}, {23'b0, mem_addr}, (a >> 2) % 512);
        chk({tag, "_be"}, {28'b0, mem_be}, e_be);
        chk({tag, "_wdata"}, mem_wdata, e_wd);
      end
      if (c == done_cyc) begin
        chk({tag, "_rdata"}, lsu_rdata, e_rd);
        chk({tag, "_err"}, {31'b0, lsu_err}, {31'b0, e_err});
      end
      lsu_valid = 1'($urandom_range(1)); lsu_store = 1'($urandom_range(1));
      L_inst = 3'($urandom_range(7)); S_inst = 2'($urandom_range(3));
      lsu_addr = $urandom; lsu_wdata = $urandom;
      mem_gnt    = (c == gcyc);
      mem_rvalid = (c == rcyc) || (c <= req_end && $urandom_range(1) == 1);
      mem_rdata  = (c == rcyc) ? word : $urandom;
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    tick();
    chk({tag, "_post_done"}, {31'b0, lsu_done}, 32'd0);
    chk({tag, "_post_ready"}, {31'b0, lsu_ready}, 32'd1);
    chk({tag, "_hold_rdata"}, lsu_rdata, e_rd);
    chk({tag, "_hold_err"}, {31'b0, lsu_err}, {31'b0, e_err});
    lsu_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; lsu_valid = 1'b0; lsu_store = 1'b0; L_inst = 3'd0; S_inst = 2'd0;
    lsu_addr = 32'd0; lsu_wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clkd);
    #1;
    chk_idle_outputs("reset");
    chk("reset_ready", {31'b0, lsu_ready}, 32'd0);
    @(negedge clkd);
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", {31'b0, lsu_ready}, 32'd1);

    run("lb_unaligned", 1'b0, 3'b001, 2'b00, 32'h0000_0013, 32'h0, 0, 1, 32'h80FF_1234);
    run("lhu_unaligned", 1'b0, 3'b110, 2'b00, 32'h0000_0012, 32'h0, 0, 1, 32'h80FF_1234);
    run("sh_gnt3", 1'b1, 3'b000, 2'b10, 32'h0000_0006, 32'hDEAD_BEEF, 3, 1, 32'h0);
    run("lw_misaligned", 1'b0, 3'b000, 2'b00, 32'h0000_0002, 32'h0, 0, 1, 32'h1234_5678);
    run("s_illegal", 1'b1, 3'b000, 2'b11, 32'h0000_0004, 32'h1111_2222, 0, 1, 32'h0);
    run("l_illegal", 1'b0, 3'b100, 2'b00, 32'h0000_0008, 32'h0, 0, 1, 32'h0);
    run("lw_timeout", 1'b0, 3'b000, 2'b00, 32'h0000_0010, 32'h0, 100, 1, 32'h0);
    run("sw_gnt_at_limit", 1'b1, 3'b000, 2'b00, 32'h0000_07FC, 32'hCAFE_F00D, TMO - 1, 1, 32'h0);
    run("lh_rvalid_at_limit", 1'b0, 3'b010, 2'b00, 32'h0000_0102, 32'h0, 5, TMO - 6, 32'h8001_7FFE);
    run("lb_rvalid_late", 1'b0, 3'b001, 2'b00, 32'h0000_0101, 32'h0, 5, TMO - 5, 32'h0000_8000);

    for (int i = 0; i < 40; i++) begin
      bit st;
      int gd, rd;
      logic [31:0] a;
      st = 1'($urandom_range(1));
      a  = $urandom;
      gd = ($urandom_range(9) < 8) ? int'($urandom_range(3)) : int'($urandom_range(TMO + 3, TMO - 3));
      rd = ($urandom_range(9) < 8) ? int'($urandom_range(3, 1)) : int'($urandom_range(TMO + 2, 9));
      run("rand", st, 3'($urandom_range(7)), 2'($urandom_range(3)), a, $urandom, gd, rd, $urandom);
    end

    // Abort a load while it waits for read data.
    chk("rst_wait_ready", {31'b0, lsu_ready}, 32'd1);
    lsu_valid = 1'b1; lsu_store = 1'b0; L_inst = 3'b000; lsu_addr = 32'h0000_0004;
    tick();
    lsu_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rst_wait_req_low", {31'b0, mem_req}, 32'd0);
    tick();
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("rst_wait");
    chk("rst_wait_ready_low", {31'b0, lsu_ready}, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_hold_done", {31'b0, lsu_done}, 32'd0);
    end
    mem_rvalid = 1'b0;
    @(negedge clkd);
    rst_n = 1'b1;
    tick();
    chk("rst_release_done", {31'b0, lsu_done}, 32'd0);
    run("sw_after_reset", 1'b1, 3'b000, 2'b00, 32'h0000_0008, 32'h0BAD_F00D, 0, 1, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
